// File: rtl/sap_pkg.sv
// Shared opcode constants for the SAP-style controller and anything that
// needs to speak its instruction set (decoder, sequencer, benches).
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/instruction_decoder.sv
// Opcode decoder for the SAP controller: zero-latency decode of the
// instruction-register opcode nibble, plus a sticky halt flop and a sticky
// "illegal opcode seen" flop. Once halted, every decode is suppressed and the
// clock gate is held off until clr.
module instruction_decoder #(
  parameter logic [3:0] OP_LDA = sap_pkg::OP_LDA,
  parameter logic [3:0] OP_ADD = sap_pkg::OP_ADD,
  parameter logic [3:0] OP_SUB = sap_pkg::OP_SUB,
  parameter logic [3:0] OP_OUT = sap_pkg::OP_OUT,
  parameter logic [3:0] OP_HLT = sap_pkg::OP_HLT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] op_code,
  output logic       lda,
  output logic       add,
  output logic       sub,
  output logic       out,
  output logic       low_halt,
  output logic       illegal,
  output logic       halted,
  output logic       err_seen
);

  logic haltedQ, haltedD;
  logic errSeenQ, errSeenD;

  // Decode the opcode; a priority chain keeps the strobes one-hot even if
  // the parameters are overridden with colliding values.
  always_comb begin
    lda      = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    out      = 1'b0;
    illegal  = 1'b0;
    low_halt = 1'b1;
    if (haltedQ || (op_code == OP_HLT)) begin
      low_halt = 1'b0;
    end
    if (!haltedQ) begin
      if (op_code == OP_LDA) begin
        lda = 1'b1;
      end else if (op_code == OP_ADD) begin
        add = 1'b1;
      end else if (op_code == OP_SUB) begin
        sub = 1'b1;
      end else if (op_code == OP_OUT) begin
        out = 1'b1;
      end else if (op_code != OP_HLT) begin
        illegal = 1'b1;
      end
    end
  end

  // Next-state for the sticky flags: they only ever set, clr clears them.
  always_comb begin
    haltedD  = haltedQ || (op_code == OP_HLT);
    errSeenD = errSeenQ || illegal;
  end

  // Sticky halt and error flops; clr releases them without waiting for clk.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      haltedQ  <= 1'b0;
      errSeenQ <= 1'b0;
    end else begin
      haltedQ  <= haltedD;
      errSeenQ <= errSeenD;
    end
  end

  assign halted   = haltedQ;
  assign err_seen = errSeenQ;

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: the stimulus process drives
// op_code/clr just after each rising edge and queues the response a simple
// rule-based model predicts; the monitor checks the DUT on every falling edge.
module tb_instruction_decoder;
  import sap_pkg::*;

  typedef struct {
    int   step;
    logic lda;
    logic add;
    logic sub;
    logic out;
    logic lowHalt;
    logic illegal;
    logic halted;
    logic errSeen;
  } expT;

  logic       clk;
  logic       clr;
  logic [3:0] opCode;
  logic       lda, add, sub, out, lowHalt, illegal, halted, errSeen;

  expT expQ[$];
  int  total = 0;
  int  bad = 0;
  int  stepNum = 0;

  // Reference model state, advanced once per rising edge.
  logic       haltM = 1'b0;
  logic       errM = 1'b0;
  logic [3:0] curOp = 4'b0000;
  logic       curClr = 1'b1;

  instruction_decoder dut (
    .clk      (clk),
    .clr      (clr),
    .op_code  (opCode),
    .lda      (lda),
    .add      (add),
    .sub      (sub),
    .out      (out),
    .low_halt (lowHalt),
    .illegal  (illegal),
    .halted   (halted),
    .err_seen (errSeen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic isKnownOp(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

  // Expected response for an opcode given the model's current sticky state.
  function automatic expT predict(input logic [3:0] op, input int stp);
    expT e;
    e.step    = stp;
    e.halted  = haltM;
    e.errSeen = errM;
    e.lda     = !haltM && (op == OP_LDA);
    e.add     = !haltM && (op == OP_ADD);
    e.sub     = !haltM && (op == OP_SUB);
    e.out     = !haltM && (op == OP_OUT);
    e.illegal = !haltM && !isKnownOp(op);
    e.lowHalt = !(haltM || (op == OP_HLT));
    return e;
  endfunction

  // One cycle: let the edge happen, update the model for it, then drive new
  // inputs and queue what the DUT should show before the next edge.
  task automatic applyStimulus(input logic [3:0] op, input logic doClr);
    @(posedge clk);
    if (!curClr) begin
      if (!haltM && !isKnownOp(curOp)) errM = 1'b1;
      if (curOp == OP_HLT) haltM = 1'b1;
    end
    #1;
    clr    = doClr;
    opCode = op;
    curClr = doClr;
    curOp  = op;
    if (doClr) begin
      haltM = 1'b0;
      errM  = 1'b0;
    end
    stepNum++;
    expQ.push_back(predict(op, stepNum));
  endtask

  task automatic checkOne(input string name, input int stp, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s step=%0d got=%b want=%b", name, stp, got, want);
    end
  endtask

  task automatic checkOutput(input expT e);
    checkOne("lda", e.step, lda, e.lda);
    checkOne("add", e.step, add, e.add);
    checkOne("sub", e.step, sub, e.sub);
    checkOne("out", e.step, out, e.out);
    checkOne("low_halt", e.step, lowHalt, e.lowHalt);
    checkOne("illegal", e.step, illegal, e.illegal);
    checkOne("halted", e.step, halted, e.halted);
    checkOne("err_seen", e.step, errSeen, e.errSeen);
    checkOne("onehot", e.step, ($countones({lda, add, sub, out}) <= 1), 1'b1);
  endtask

  // Monitor: whenever a prediction is pending, compare it mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    clr    = 1'b1;
    opCode = 4'b0000;

    // Reset pulse, then basic decodes.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b1110, 1'b0);

    // Halt: low_halt drops first, halted follows on the edge.
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0101, 1'b0);

    // clr while halted releases immediately; add decodes again.
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0001, 1'b0);

    // Illegal opcode sets err_seen, which sticks until clr.
    applyStimulus(4'b0101, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    // HLT held across an edge while clr is asserted: reset wins.
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    // All 16 opcodes while held in reset, then 0..14 un-reset.
    for (int i = 0; i < 16; i++) applyStimulus(4'(i), 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(4'(i), 1'b0);
    applyStimulus(4'b0000, 1'b1);

    // Random traffic with occasional clr to escape halts.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end
    applyStimulus(4'b0000, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 Parameter OP_LDA, default 4'b0000, load-accumulator opcode.
REQ-002 Parameter OP_ADD, default 4'b0001, add opcode.
REQ-003 Parameter OP_SUB, default 4'b0010, subtract opcode.
REQ-004 Parameter OP_OUT, default 4'b1110, output opcode.
REQ-005 Parameter OP_HLT, default 4'b1111, halt opcode.
REQ-006 Port clk  input  1  single system clock, rising-edge active.
REQ-007 Port clr  input  1  asynchronous, active-high reset.
REQ-008 Port op_code  input  4  opcode nibble (upper half of instruction register).
REQ-009 Port lda  output  1  active-high, LDA decoded.
REQ-010 Port add  output  1  active-high, ADD decoded.
REQ-011 Port sub  output  1  active-high, SUB decoded.
REQ-012 Port out  output  1  active-high, OUT decoded.
REQ-013 Port low_halt  output  1  active-low halt request to the clock gate.
REQ-014 Port illegal  output  1  active-high, op_code matches no defined opcode.
REQ-015 Port halted  output  1  sticky registered halt state.
REQ-016 Port err_seen  output  1  sticky registered flag, illegal opcode seen since reset.

Function
REQ-017 lda/add/sub/out SHALL be purely combinational from op_code, zero-cycle latency.
REQ-018 lda SHALL be 1 iff op_code==OP_LDA and halted==0; add, sub, out likewise with their opcodes.
REQ-019 At most one of lda/add/sub/out SHALL be 1 at any time (one-hot or all-zero).
REQ-020 low_halt SHALL be 0 when op_code==OP_HLT or halted==1, else 1 (combinational, zero latency).
REQ-021 illegal SHALL be 1 iff op_code is none of the five opcodes and halted==0 (opcodes 0011-1101 by default).
REQ-022 halted SHALL be set on the rising clk edge where op_code==OP_HLT; it SHALL remain 1 until clr.
REQ-023 While halted==1, lda/add/sub/out/illegal SHALL be 0 and low_halt 0 regardless of op_code.
REQ-024 err_seen SHALL be set on the rising clk edge where illegal==1; remains 1 until clr.
REQ-025 Decoding with OP_HLT on op_code SHALL drive lda/add/sub/out/illegal all 0.

Reset
REQ-026 clr==1 SHALL asynchronously force halted=0 and err_seen=0, independent of clk.
REQ-027 During and after reset, combinational outputs SHALL follow op_code per REQ-017..021 with halted=0.
REQ-028 clr asserted while halted SHALL release halt immediately (low_halt returns to 1 unless op_code==OP_HLT).
REQ-029 clr and a HLT-setting edge in the same cycle SHALL leave halted=0 (reset wins).

Structure
REQ-030 Opcode constants (OP_LDA..OP_HLT) SHALL live in shared package sap_pkg, reused by controller and bench; module parameters default to them.
REQ-031 Implementation SHALL be flat: one combinational decode block plus two flops; no sub-module.

Verification
REQ-032 clr pulse, then op_code 0000 -> lda=1, add=sub=out=0, low_halt=1, illegal=0, halted=0.
REQ-033 op_code sweeps 0001, 0010, 1110 (no clk edge) -> add, sub, out respectively 1, others 0, low_halt=1.
REQ-034 op_code 1111 before edge -> low_halt=0, halted=0; after one clk edge halted=1; op_code then 0000 -> lda=0, low_halt=0.
REQ-035 Halted state, assert clr mid-cycle -> halted=0 immediately; op_code 0001 -> add=1, low_halt=1.
REQ-036 op_code 0101 -> illegal=1, all decodes 0, low_halt=1; after clk edge err_seen=1; op_code 0000 keeps err_seen=1 until clr.
REQ-037 Exhaustive sweep of all 16 opcodes with halted=0 -> exactly one of lda/add/sub/out/illegal/(low_halt==0) active per value.
